prog_loader: RTL and testbench

Bus-master program loader for the nam85 CPU. It takes a byte stream from a host over a valid/ready handshake and writes each byte into the memory block through the shared 16-bit bus, using the same MAR-then-write sequence the controller issues. While it loads, it holds the CPU in reset and claims the bus, so a test or boot sequence can place a program in memory without a preloaded image.

---
 rtl/prog_loader_pkg.sv | 29 ++
 rtl/prog_loader.sv | 191 +++++++++++++++++++
 tb/tb_prog_loader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared nam85 bus definitions used by the program loader and
//               the top-level bus mux. Holds the bus width and the priority
//               rule that puts the loader's drive ahead of every other source.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    // Width of the shared nam85 data/address bus and of the MAR.
    localparam int C_BUS_W  = 16;

    // Width of one memory byte; the memory writes bus[C_BYTE_W-1:0].
    localparam int C_BYTE_W = 8;

    // Top-level bus mux priority: when the loader asserts its enable it
    // owns the bus outright, regardless of what the controller, ALU,
    // regfile or memory would otherwise drive.
    function automatic logic [C_BUS_W-1:0] bus_mux_prio(
        input logic               loader_en,
        input logic [C_BUS_W-1:0] loader_val,
        input logic [C_BUS_W-1:0] other_val
    );
        return loader_en ? loader_val : other_val;
    endfunction

endpackage : prog_loader_pkg
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Bus-master program loader for the nam85 CPU. Accepts a byte
//               stream over a valid/ready handshake and writes each byte to
//               memory with the same MAR-then-write sequence the controller
//               uses, while holding the CPU in reset and owning the bus.
// Ports       : clk          - system clock, rising edge
//               rst          - asynchronous reset, active low
//               start        - one-cycle load request (honoured in IDLE only)
//               base_addr    - first memory address, sampled with start
//               len          - byte count, sampled with start (0 allowed)
//               in_valid     - host byte available
//               in_data      - host byte
//               in_ready     - loader accepts in_data this cycle
//               bus_out      - value driven onto the shared bus
//               bus_out_en   - loader owns the bus (top mux priority)
//               mar_write_en - memory latches bus into MAR on next edge
//               mem_write_en - memory writes bus[7:0] to mem[MAR] next edge
//               cpu_hold     - ORed into the CPU reset while loading
//               busy         - loader is not in IDLE
//               done         - one-cycle pulse at load completion
//               count        - bytes written so far in the current load
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = C_BUS_W,
    parameter int LEN_W  = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] bus_out,
    output logic              bus_out_en,
    output logic              mar_write_en,
    output logic              mem_write_en,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  count
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_WAIT_DATA = 3'd2;
    localparam logic [2:0] S_WRITE     = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [ADDR_W-1:0] c_addr_one   = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  c_len_one    = LEN_W'(1);
    localparam logic [LEN_W-1:0]  c_len_zero   = '0;
    localparam logic [ADDR_W-C_BYTE_W-1:0] c_byte_pad = '0;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;

    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_remain;
    logic [C_BYTE_W-1:0] r_data;
    logic [LEN_W-1:0]    r_count;

    // Start is only honoured from IDLE; anywhere else it is ignored.
    logic w_start_acc;
    logic w_byte_acc;
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_byte_acc  = (r_state == S_WAIT_DATA) && in_valid;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // A zero-length load skips the bus entirely.
                    w_state_nxt = (len == c_len_zero) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                w_state_nxt = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (in_valid) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                // r_remain still holds the pre-decrement value here, so 1
                // means this write is the last byte.
                w_state_nxt = (r_remain == c_len_one) ? S_DONE : S_ADDR;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        in_ready     = 1'b0;
        bus_out      = '0;
        bus_out_en   = 1'b0;
        mar_write_en = 1'b0;
        mem_write_en = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_ADDR: begin
                bus_out      = r_addr;
                bus_out_en   = 1'b1;
                mar_write_en = 1'b1;
            end
            S_WAIT_DATA: begin
                // Keep the bus claimed between ADDR and WRITE so no other
                // source can disturb MAR/memory mid-transfer.
                in_ready     = 1'b1;
                bus_out_en   = 1'b1;
            end
            S_WRITE: begin
                bus_out      = {c_byte_pad, r_data};
                bus_out_en   = 1'b1;
                mem_write_en = 1'b1;
            end
            S_DONE: begin
                done         = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy     = (r_state != S_IDLE);
    assign cpu_hold = (r_state != S_IDLE);
    assign count    = r_count;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr   <= '0;
            r_remain <= '0;
            r_count  <= '0;
        end else if (w_start_acc) begin
            r_addr   <= base_addr;
            r_remain <= len;
            r_count  <= '0;
        end else if (r_state == S_WRITE) begin
            // Address wraps naturally from all-ones to zero.
            r_addr   <= r_addr + c_addr_one;
            r_remain <= r_remain - c_len_one;
            r_count  <= r_count + c_len_one;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (w_byte_acc) begin
            r_data <= in_data;
        end
    end

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. A cycle-by-cycle vector
//               table covers back-to-back loads, address wrap, zero length
//               and ignored start pulses; hand-written sequences cover host
//               stalls and asynchronous reset mid-load. A small memory model
//               reacts to the loader's MAR/write strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [16:0] len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [15:0] bus_out;
    logic        bus_out_en;
    logic        mar_write_en;
    logic        mem_write_en;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic [16:0] count;

    prog_loader #(.ADDR_W(16), .LEN_W(17)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .len          (len),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .bus_out      (bus_out),
        .bus_out_en   (bus_out_en),
        .mar_write_en (mar_write_en),
        .mem_write_en (mem_write_en),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory block model: MAR latch plus byte array, never reset.
    logic [15:0] mar;
    logic [7:0]  mem [0:65535];
    always @(posedge clk) begin
        if (mar_write_en) mar <= bus_out;
        if (mem_write_en) mem[mar] <= bus_out[7:0];
    end

    typedef struct packed {
        logic        ir;
        logic [15:0] bus;
        logic        en;
        logic        mar;
        logic        mem;
        logic        hold;
        logic        busy;
        logic        done;
        logic [16:0] cnt;
    } outs_t;

    typedef struct {
        logic        st;
        logic [15:0] base;
        logic [16:0] len;
        logic        v;
        logic [7:0]  d;
        outs_t       exp;
    } vec_t;

    int n_vec;
    int n_bad;

    function automatic outs_t o(input logic ir, input logic [15:0] bus,
                                input logic en, input logic mr, input logic mw,
                                input logic bz, input logic dn, input logic [16:0] cnt);
        outs_t r;
        r.ir = ir; r.bus = bus; r.en = en; r.mar = mr; r.mem = mw;
        r.hold = bz; r.busy = bz; r.done = dn; r.cnt = cnt;
        return r;
    endfunction

    // Expected outputs per loader state.
    function automatic outs_t s_idle(input logic [16:0] c);                    return o(0, 16'h0, 0, 0, 0, 0, 0, c); endfunction
    function automatic outs_t s_addr(input logic [15:0] a, input logic [16:0] c); return o(0, a, 1, 1, 0, 1, 0, c); endfunction
    function automatic outs_t s_wait(input logic [16:0] c);                    return o(1, 16'h0, 1, 0, 0, 1, 0, c); endfunction
    function automatic outs_t s_wr(input logic [7:0] d, input logic [16:0] c); return o(0, {8'h00, d}, 1, 0, 1, 1, 0, c); endfunction
    function automatic outs_t s_done(input logic [16:0] c);                    return o(0, 16'h0, 0, 0, 0, 1, 1, c); endfunction

    function automatic vec_t mk(input logic st, input logic [15:0] b, input logic [16:0] l,
                                input logic v, input logic [7:0] d, input outs_t e);
        vec_t r;
        r.st = st; r.base = b; r.len = l; r.v = v; r.d = d; r.exp = e;
        return r;
    endfunction

    function automatic outs_t actual();
        outs_t r;
        r.ir = in_ready; r.bus = bus_out; r.en = bus_out_en; r.mar = mar_write_en;
        r.mem = mem_write_en; r.hold = cpu_hold; r.busy = busy; r.done = done; r.cnt = count;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Runs one load of up to two bytes with in_valid withheld for 'stall'
    // WAIT_DATA cycles after the first ADDR. Cycle 0 is the start cycle.
    task automatic run_load(input logic [15:0] base, input logic [16:0] n,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input int stall, output int done_cyc);
        int idx;
        idx      = 0;
        done_cyc = -1;
        tick();
        start = 1'b1; base_addr = base; len = n; in_valid = (stall == 0); in_data = b0;
        for (int c = 1; c < 60; c++) begin
            tick();
            start    = 1'b0;
            in_valid = !(c >= 2 && c < 2 + stall);
            #1;
            if (c >= 2 && c < 2 + stall)
                check($sformatf("stall_c%0d", c), {62'd0, in_ready, mem_write_en}, {62'd0, 1'b1, 1'b0});
            if (in_ready) in_data = (idx == 0) ? b0 : b1;
            if (in_ready && in_valid) idx++;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        if (done_cyc < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL load_timeout: got no done, expected done within 60 cycles");
        end
    endtask

    vec_t vecs [0:21];
    int   dc;

    initial begin
        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mar = 16'h0000;
        rst = 1'b0; start = 1'b0; base_addr = 16'h0; len = 17'h0; in_valid = 1'b0; in_data = 8'h0;

        // Load A: 3 bytes at 0x0010, start re-pulsed mid-load and in DONE.
        vecs[0]  = mk(1, 16'h0010, 17'd3, 1, 8'h00, s_idle(0));
        vecs[1]  = mk(0, 16'h0000, 17'd0, 1, 8'h00, s_addr(16'h0010, 0));
        vecs[2]  = mk(0, 16'h0000, 17'd0, 1, 8'hA1, s_wait(0));
        vecs[3]  = mk(0, 16'h0000, 17'd0, 1, 8'h00, s_wr(8'hA1, 0));
        vecs[4]  = mk(0, 16'h0000, 17'd0, 1, 8'h00, s_addr(16'h0011, 1));
        vecs[5]  = mk(1, 16'h9999, 17'd7, 1, 8'hB2, s_wait(1));
        vecs[6]  = mk(0, 16'h0000, 17'd0, 1, 8'h00, s_wr(8'hB2, 1));
        vecs[7]  = mk(0, 16'h0000, 17'd0, 1, 8'h00, s_addr(16'h0012, 2));
        vecs[8]  = mk(0, 16'h0000, 17'd0, 1, 8'hC3, s_wait(2));
        vecs[9]  = mk(0, 16'h0000, 17'd0, 1, 8'h00, s_wr(8'hC3, 2));
        vecs[10] = mk(1, 16'h1234, 17'd5, 1, 8'h00, s_done(3));
        // Load B: 2 bytes wrapping from 0xFFFF to 0x0000.
        vecs[11] = mk(1, 16'hFFFF, 17'd2, 1, 8'h00, s_idle(3));
        vecs[12] = mk(0, 16'h0000, 17'd0, 1, 8'h00, s_addr(16'hFFFF, 0));
        vecs[13] = mk(0, 16'h0000, 17'd0, 1, 8'h5A, s_wait(0));
        vecs[14] = mk(0, 16'h0000, 17'd0, 1, 8'h00, s_wr(8'h5A, 0));
        vecs[15] = mk(0, 16'h0000, 17'd0, 1, 8'h00, s_addr(16'h0000, 1));
        vecs[16] = mk(0, 16'h0000, 17'd0, 1, 8'h6B, s_wait(1));
        vecs[17] = mk(0, 16'h0000, 17'd0, 1, 8'h00, s_wr(8'h6B, 1));
        vecs[18] = mk(0, 16'h0000, 17'd0, 1, 8'h00, s_done(2));
        // Load C: zero length goes straight to DONE with no bus strobes.
        vecs[19] = mk(1, 16'h0040, 17'd0, 1, 8'h00, s_idle(2));
        vecs[20] = mk(0, 16'h0000, 17'd0, 1, 8'h00, s_done(0));
        vecs[21] = mk(0, 16'h0000, 17'd0, 1, 8'h00, s_idle(0));

        // Reset state.
        tick();
        #1;
        check("reset_outputs", {24'd0, actual()}, {24'd0, s_idle(0)});
        tick();
        rst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            tick();
            start = vecs[i].st; base_addr = vecs[i].base; len = vecs[i].len;
            in_valid = vecs[i].v; in_data = vecs[i].d;
            #1;
            check($sformatf("vec%0d", i), {24'd0, actual()}, {24'd0, vecs[i].exp});
        end
        start = 1'b0; in_valid = 1'b0;

        check("mem_0010", {56'd0, mem[16'h0010]}, {56'd0, 8'hA1});
        check("mem_0011", {56'd0, mem[16'h0011]}, {56'd0, 8'hB2});
        check("mem_0012", {56'd0, mem[16'h0012]}, {56'd0, 8'hC3});
        check("mem_FFFF", {56'd0, mem[16'hFFFF]}, {56'd0, 8'h5A});
        check("mem_0000", {56'd0, mem[16'h0000]}, {56'd0, 8'h6B});
        check("mem_0040", {56'd0, mem[16'h0040]}, {56'd0, 8'h00});

        // Host stalls 5 cycles after the first ADDR: done 5 cycles late.
        run_load(16'h0200, 17'd2, 8'h11, 8'h22, 5, dc);
        check("stall_done_cycle", 64'(dc), 64'd12);
        check("stall_count", {47'd0, count}, 64'd2);
        check("mem_0200", {56'd0, mem[16'h0200]}, {56'd0, 8'h11});
        check("mem_0201", {56'd0, mem[16'h0201]}, {56'd0, 8'h22});

        // Reset asserted one cycle after the first WRITE of a 4-byte load.
        tick();
        start = 1'b1; base_addr = 16'h0300; len = 17'd4; in_valid = 1'b1; in_data = 8'h00;
        tick();
        start = 1'b0;
        tick();
        in_data = 8'h71;
        tick();
        #1;
        check("rst_pre_write", {24'd0, actual()}, {24'd0, s_wr(8'h71, 0)});
        tick();
        rst = 1'b0;
        #1;
        check("rst_async_outputs", {24'd0, actual()}, {24'd0, s_idle(0)});
        tick();
        rst = 1'b1; in_valid = 1'b0;
        check("rst_mem_0300", {56'd0, mem[16'h0300]}, {56'd0, 8'h71});
        check("rst_mem_0301", {56'd0, mem[16'h0301]}, {56'd0, 8'h00});

        // Normal load after reset release: 2 bytes, done in cycle 7.
        run_load(16'h0400, 17'd2, 8'h81, 8'h82, 0, dc);
        check("post_rst_done_cycle", 64'(dc), 64'd7);
        check("mem_0400", {56'd0, mem[16'h0400]}, {56'd0, 8'h81});
        check("mem_0401", {56'd0, mem[16'h0401]}, {56'd0, 8'h82});
        tick();
        #1;
        check("post_rst_idle", {24'd0, actual()}, {24'd0, s_idle(2)});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_prog_loader
`default_nettype wire
